// File: rtl/packet_receive_local_if.sv
// Ejection-port handshake between the ring router's local output and the
// packet sink. A packet transfers on a clock edge where packet_valid and
// packet_ready are both high.
interface packet_receive_local_if #(
    parameter int PACKET_SIZE = 49
);
    logic                   packet_valid;
    logic [PACKET_SIZE-1:0] packet;
    logic                   packet_ready;

    // Router side: presents packets and observes backpressure
    modport master (
        output packet_valid,
        output packet,
        input  packet_ready
    );

    // Sink side: consumes packets and drives backpressure
    modport slave (
        input  packet_valid,
        input  packet,
        output packet_ready
    );
endinterface

// File: rtl/packet_receive_local.sv
// packet_receive_local: local ejection sink of a ring router.
// Classifies each ejected packet (good / misrouted / malformed), computes its
// network latency from the embedded injection timestamp, and accumulates
// end-of-run statistics.
// Pipeline: stage 1 captures the packet on its transfer edge, stage 2 updates
// the statistics on the following edge.
// Packet layout: {valid[48], timestamp[47:32], src[31:16], dst[15:0]}.
// Optional feature macro: PKT_RX_PER_SRC_CNT_EN adds per-source good-packet
// counters readable through src_sel/src_count.
module packet_receive_local #(
    parameter int NUM_NODES        = 8,
    parameter int ROUTER_ID        = 0,
    parameter int PACKET_SIZE      = 49,
    parameter int EXPECTED_PACKETS = 20
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [15:0]                  clk_counter,
    packet_receive_local_if.slave        pkt,
    input  logic                         stats_clear,
    output logic [63:0]                  total_packet_recv,
    output logic [63:0]                  total_latency,
    output logic [15:0]                  max_latency,
    output logic [15:0]                  min_latency,
    output logic [15:0]                  misroute_cnt,
    output logic [15:0]                  malformed_cnt,
    output logic                         recv_done,
    input  logic [15:0]                  src_sel,
    output logic [15:0]                  src_count
);

    localparam int          SRC_W    = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;
    localparam logic [15:0] NODES_16 = 16'(NUM_NODES);
    localparam logic [15:0] RID_16   = 16'(ROUTER_ID);
    localparam logic [63:0] EXP_64   = 64'(EXPECTED_PACKETS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [1:0] CLS_GOOD = 2'd0;
    localparam logic [1:0] CLS_MIS  = 2'd1;
    localparam logic [1:0] CLS_MAL  = 2'd2;

    // Error counters hold at all-ones rather than wrapping to zero
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [1:0]  r_state;
    logic [1:0]  w_state_next;
    logic        w_ready;
    logic        w_xfer;
    logic        w_vbit;
    logic [15:0] w_ts;
    logic [15:0] w_src;
    logic [15:0] w_dst;
    logic [1:0]  w_cls;
    logic        w_good_p1;
    logic [63:0] w_recv_next;

    logic        vld_p1;
    logic [1:0]  cls_p1;
    logic [15:0] lat_p1;

    logic [63:0] r_total_recv;
    logic [63:0] r_total_lat;
    logic [15:0] r_max_lat;
    logic [15:0] r_min_lat;
    logic [15:0] r_mis_cnt;
    logic [15:0] r_mal_cnt;

    assign w_vbit = pkt.packet[PACKET_SIZE-1];
    assign w_ts   = pkt.packet[47:32];
    assign w_src  = pkt.packet[31:16];
    assign w_dst  = pkt.packet[15:0];

    // Sink is ready once out of IDLE, except while a clear is being applied
    assign w_ready          = (r_state != S_IDLE) && !stats_clear;
    assign pkt.packet_ready = w_ready;
    assign w_xfer           = pkt.packet_valid && w_ready;

    // Classify the packet on the ejection port
    always_comb begin
        w_cls = CLS_MAL;
        if (w_vbit) begin
            if ((w_dst == RID_16) && (w_src < NODES_16)) w_cls = CLS_GOOD;
            else                                         w_cls = CLS_MIS;
        end
    end

    assign w_good_p1   = vld_p1 && (cls_p1 == CLS_GOOD);
    assign w_recv_next = r_total_recv + {63'd0, w_good_p1};

    // Next-state logic: clear forces RUN; DONE is entered when the count is reached
    always_comb begin
        w_state_next = r_state;
        if (stats_clear) begin
            w_state_next = S_RUN;
        end else begin
            case (r_state)
                S_IDLE:  w_state_next = (EXP_64 == 64'd0) ? S_DONE : S_RUN;
                S_RUN:   if (w_recv_next >= EXP_64) w_state_next = S_DONE;
                S_DONE:  w_state_next = S_DONE;
                default: w_state_next = S_RUN;
            endcase
        end
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // ---- stage 1: capture on transfer edge (control) ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1 <= 1'b0;
            cls_p1 <= CLS_MAL;
        end else if (stats_clear) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= w_xfer;
            if (w_xfer) cls_p1 <= w_cls;
        end
    end

    // Stage 1 data: modular subtract absorbs timestamp wrap-around
    always_ff @(posedge clk) begin
        if (w_xfer) lat_p1 <= clk_counter - w_ts;
    end

    // ---- stage 2: statistics update; clear has priority over the update ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_total_recv <= 64'd0;
            r_total_lat  <= 64'd0;
            r_max_lat    <= 16'd0;
            r_min_lat    <= 16'hFFFF;
            r_mis_cnt    <= 16'd0;
            r_mal_cnt    <= 16'd0;
        end else if (stats_clear) begin
            r_total_recv <= 64'd0;
            r_total_lat  <= 64'd0;
            r_max_lat    <= 16'd0;
            r_min_lat    <= 16'hFFFF;
            r_mis_cnt    <= 16'd0;
            r_mal_cnt    <= 16'd0;
        end else if (vld_p1) begin
            case (cls_p1)
                CLS_GOOD: begin
                    r_total_recv <= w_recv_next;
                    r_total_lat  <= r_total_lat + {48'd0, lat_p1};
                    if (lat_p1 > r_max_lat) r_max_lat <= lat_p1;
                    if (lat_p1 < r_min_lat) r_min_lat <= lat_p1;
                end
                CLS_MIS: r_mis_cnt <= sat_inc16(r_mis_cnt);
                default: r_mal_cnt <= sat_inc16(r_mal_cnt);
            endcase
        end
    end

    assign total_packet_recv = r_total_recv;
    assign total_latency     = r_total_lat;
    assign max_latency       = r_max_lat;
    assign min_latency       = r_min_lat;
    assign misroute_cnt      = r_mis_cnt;
    assign malformed_cnt     = r_mal_cnt;
    assign recv_done         = (r_state == S_DONE);

`ifdef PKT_RX_PER_SRC_CNT_EN
    logic [SRC_W-1:0] src_p1;
    logic [15:0]      r_src_cnt [NUM_NODES];
    logic [15:0]      w_src_count;

    // Stage 1 data: source index of the captured packet
    always_ff @(posedge clk) begin
        if (w_xfer) src_p1 <= w_src[SRC_W-1:0];
    end

    // Stage 2: per-source good-packet counters, saturating
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_NODES; i++) r_src_cnt[i] <= 16'd0;
        end else if (stats_clear) begin
            for (int i = 0; i < NUM_NODES; i++) r_src_cnt[i] <= 16'd0;
        end else if (w_good_p1) begin
            r_src_cnt[src_p1] <= sat_inc16(r_src_cnt[src_p1]);
        end
    end

    // Read port: out-of-range selections read as zero
    always_comb begin
        w_src_count = 16'd0;
        if (src_sel < NODES_16) w_src_count = r_src_cnt[src_sel[SRC_W-1:0]];
    end

    assign src_count = w_src_count;
`else
    logic w_unused_sel;

    assign w_unused_sel = ^src_sel;
    assign src_count    = 16'd0;
`endif

endmodule

// File: tb/tb_packet_receive_local.sv
// Directed testbench for packet_receive_local (ROUTER_ID = 7, 8 nodes,
// 20 expected packets). Every expected value is hand-computed.
module tb_packet_receive_local;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] clk_counter;
    logic        stats_clear;
    logic [15:0] src_sel;
    logic [63:0] total_packet_recv;
    logic [63:0] total_latency;
    logic [15:0] max_latency;
    logic [15:0] min_latency;
    logic [15:0] misroute_cnt;
    logic [15:0] malformed_cnt;
    logic        recv_done;
    logic [15:0] src_count;

    int errors = 0;
    int checks = 0;

    packet_receive_local_if #(.PACKET_SIZE(49)) pif ();

    packet_receive_local #(
        .NUM_NODES        (8),
        .ROUTER_ID        (7),
        .PACKET_SIZE      (49),
        .EXPECTED_PACKETS (20)
    ) dut (
        .clk               (clk),
        .rst               (rst),
        .clk_counter       (clk_counter),
        .pkt               (pif),
        .stats_clear       (stats_clear),
        .total_packet_recv (total_packet_recv),
        .total_latency     (total_latency),
        .max_latency       (max_latency),
        .min_latency       (min_latency),
        .misroute_cnt      (misroute_cnt),
        .malformed_cnt     (malformed_cnt),
        .recv_done         (recv_done),
        .src_sel           (src_sel),
        .src_count         (src_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic v, input logic [15:0] ts, input logic [15:0] src,
                           input logic [15:0] dst, input logic [15:0] cc);
        pif.packet_valid = 1'b1;
        pif.packet       = {v, ts, src, dst};
        clk_counter      = cc;
    endtask

    task automatic idle();
        pif.packet_valid = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        stats_clear      = 1'b0;
        clk_counter      = 16'd0;
        src_sel          = 16'd0;
        pif.packet_valid = 1'b0;
        pif.packet       = '0;
        tick();
        tick();
        chk("rst_recv", total_packet_recv, 64'd0);
        chk("rst_lat", total_latency, 64'd0);
        chk("rst_max", {48'd0, max_latency}, 64'd0);
        chk("rst_min", {48'd0, min_latency}, 64'hFFFF);
        chk("rst_mis", {48'd0, misroute_cnt}, 64'd0);
        chk("rst_mal", {48'd0, malformed_cnt}, 64'd0);
        chk("rst_done", {63'd0, recv_done}, 64'd0);
        chk("rst_ready", {63'd0, pif.packet_ready}, 64'd0);
        rst = 1'b0;
        #1;
        chk("idle_ready", {63'd0, pif.packet_ready}, 64'd0);
        tick();
        chk("run_ready", {63'd0, pif.packet_ready}, 64'd1);

        // First good packet: latency 130 - 100 = 30
        present(1'b1, 16'd100, 16'd0, 16'd7, 16'd130);
        tick();
        idle();
        chk("p1_not_yet", total_packet_recv, 64'd0);
        tick();
        chk("p1_recv", total_packet_recv, 64'd1);
        chk("p1_lat", total_latency, 64'd30);
        chk("p1_max", {48'd0, max_latency}, 64'd30);
        chk("p1_min", {48'd0, min_latency}, 64'd30);

        // Timestamp wrap: 0x0010 - 0xFFF0 = 32 (mod 2^16)
        present(1'b1, 16'hFFF0, 16'd1, 16'd7, 16'h0010);
        tick();
        idle();
        tick();
        chk("wrap_recv", total_packet_recv, 64'd2);
        chk("wrap_lat", total_latency, 64'd62);
        chk("wrap_max", {48'd0, max_latency}, 64'd32);
        chk("wrap_min", {48'd0, min_latency}, 64'd30);

        // Error classes: wrong dst, out-of-range src, then malformed
        present(1'b1, 16'd10, 16'd2, 16'd3, 16'd20);
        tick();
        present(1'b1, 16'd10, 16'd9, 16'd7, 16'd20);
        tick();
        present(1'b0, 16'd10, 16'd2, 16'd7, 16'd20);
        tick();
        idle();
        tick();
        chk("err_mis", {48'd0, misroute_cnt}, 64'd2);
        chk("err_mal", {48'd0, malformed_cnt}, 64'd1);
        chk("err_recv", total_packet_recv, 64'd2);
        chk("err_lat", total_latency, 64'd62);

        // Clear, then 20 back-to-back good packets with latencies 1..20
        stats_clear = 1'b1;
        #1;
        chk("clr_ready", {63'd0, pif.packet_ready}, 64'd0);
        tick();
        stats_clear = 1'b0;
        chk("clr_mis", {48'd0, misroute_cnt}, 64'd0);
        chk("clr_min", {48'd0, min_latency}, 64'hFFFF);
        for (int i = 1; i <= 20; i++) begin
            present(1'b1, 16'd1000, 16'(i % 8), 16'd7, 16'(1000 + i));
            tick();
        end
        idle();
        chk("b2b_recv19", total_packet_recv, 64'd19);
        chk("b2b_done19", {63'd0, recv_done}, 64'd0);
        tick();
        chk("b2b_recv20", total_packet_recv, 64'd20);
        chk("b2b_done20", {63'd0, recv_done}, 64'd1);
        chk("b2b_lat", total_latency, 64'd210);
        chk("b2b_min", {48'd0, min_latency}, 64'd1);
        chk("b2b_max", {48'd0, max_latency}, 64'd20);
        present(1'b1, 16'd50, 16'd3, 16'd7, 16'd55);
        tick();
        idle();
        tick();
        chk("p21_recv", total_packet_recv, 64'd21);
        chk("p21_done", {63'd0, recv_done}, 64'd1);
        chk("p21_lat", total_latency, 64'd215);

        // Clear with packet A in stage 1 and packet B on the port
        present(1'b1, 16'd0, 16'd1, 16'd7, 16'd3);
        tick();
        present(1'b1, 16'd0, 16'd1, 16'd7, 16'd4);
        stats_clear = 1'b1;
        #1;
        chk("inflt_ready", {63'd0, pif.packet_ready}, 64'd0);
        tick();
        stats_clear = 1'b0;
        idle();
        chk("inflt_recv", total_packet_recv, 64'd0);
        chk("inflt_lat", total_latency, 64'd0);
        chk("inflt_max", {48'd0, max_latency}, 64'd0);
        chk("inflt_min", {48'd0, min_latency}, 64'hFFFF);
        chk("inflt_done", {63'd0, recv_done}, 64'd0);
        tick();
        chk("inflt_recv2", total_packet_recv, 64'd0);
        chk("inflt_lat2", total_latency, 64'd0);

        // Per-source: 3 from src 2, 1 from src 5
        present(1'b1, 16'd0, 16'd2, 16'd7, 16'd1);
        tick();
        tick();
        tick();
        present(1'b1, 16'd0, 16'd5, 16'd7, 16'd1);
        tick();
        idle();
        tick();
        chk("src_recv", total_packet_recv, 64'd4);
`ifdef PKT_RX_PER_SRC_CNT_EN
        src_sel = 16'd2;
        #1;
        chk("src2", {48'd0, src_count}, 64'd3);
        src_sel = 16'd5;
        #1;
        chk("src5", {48'd0, src_count}, 64'd1);
        src_sel = 16'd9;
        #1;
        chk("src9", {48'd0, src_count}, 64'd0);
`else
        src_sel = 16'd2;
        #1;
        chk("src_tied", {48'd0, src_count}, 64'd0);
`endif

        // Asynchronous reset mid-run, with a packet in stage 1
        present(1'b1, 16'd0, 16'd1, 16'd7, 16'd9);
        tick();
        idle();
        rst = 1'b1;
        #1;
        chk("arst_recv", total_packet_recv, 64'd0);
        chk("arst_ready", {63'd0, pif.packet_ready}, 64'd0);
        tick();
        rst = 1'b0;
        tick();
        tick();
        chk("arst_recv2", total_packet_recv, 64'd0);
        chk("arst_ready2", {63'd0, pif.packet_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
